// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI transmit-path arbiter.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE,
    FINISH
  } arb_state_t;

  localparam int SPI_FRAME_W     = 12;
  localparam int DEFAULT_TIMEOUT = 1023;

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational winner select: round-robin from ptr, or lowest index wins when
// SPI_ARB_FIXED_PRI_EN is defined (ptr port is then absent).
module spi_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
`ifndef SPI_ARB_FIXED_PRI_EN
  input  logic [PTR_W-1:0]   ptr,
`endif
  output logic [NUM_REQ-1:0] win_oh,
  output logic [PTR_W-1:0]   win_idx,
  output logic               vld
);

`ifdef SPI_ARB_FIXED_PRI_EN
  // Scan high to low so the lowest set index is the last one written.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    vld     = |req;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        win_idx = PTR_W'(k);
        win_oh  = NUM_REQ'(1) << k;
      end
    end
  end
`else
  logic [PTR_W:0] sum;

  // Walk upward from ptr with wrap-around; the first set bit wins.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    vld     = 1'b0;
    sum     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (PTR_W + 1)'(k);
      if (sum >= (PTR_W + 1)'(NUM_REQ)) begin
        sum = sum - (PTR_W + 1)'(NUM_REQ);
      end
      if (!vld && req[sum[PTR_W-1:0]]) begin
        vld                      = 1'b1;
        win_idx                  = sum[PTR_W-1:0];
        win_oh[sum[PTR_W-1:0]]   = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/spi_txn_arbiter.sv
// Grants one SPI frame at a time to NUM_REQ requesters, drives start/data, tracks busy,
// acks with err on timeout. All outputs registered; SPI_ARB_FIXED_PRI_EN selects fixed priority.
module spi_txn_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = SPI_FRAME_W,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      err,
  output logic                      m_start,
  output logic [DATA_W-1:0]         m_data,
  input  logic                      m_busy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT);

  arb_state_t          state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                err_q, err_d;
  logic                m_start_q, m_start_d;
  logic [DATA_W-1:0]   m_data_q, m_data_d;
  logic [TMR_W-1:0]    timer_q, timer_d;

  logic [NUM_REQ-1:0]  pick_oh;
  logic [PTR_W-1:0]    pick_idx;
  logic                pick_vld;
  logic                timed_out;

`ifndef SPI_ARB_FIXED_PRI_EN
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    win_q, win_d;
`endif

  spi_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req     (req),
`ifndef SPI_ARB_FIXED_PRI_EN
    .ptr     (ptr_q),
`endif
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .vld     (pick_vld)
  );

  assign timed_out = (timer_q == TMR_MAX);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ack_d     = '0;
    err_d     = 1'b0;
    m_start_d = 1'b0;
    m_data_d  = m_data_q;
    timer_d   = timed_out ? timer_q : timer_q + TMR_W'(1);
`ifndef SPI_ARB_FIXED_PRI_EN
    ptr_d     = ptr_q;
    win_d     = win_q;
`endif

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_d     = pick_oh;
          m_data_d  = req_data[int'(pick_idx)*DATA_W +: DATA_W];
          m_start_d = 1'b1;
          state_d   = WAIT_BUSY;
`ifndef SPI_ARB_FIXED_PRI_EN
          win_d     = pick_idx;
`endif
        end
      end
      // Busy is checked before the timer so a late rise still completes cleanly.
      WAIT_BUSY: begin
        if (m_busy) begin
          state_d = WAIT_DONE;
        end else if (timed_out) begin
          state_d = FINISH;
          ack_d   = gnt_q;
          err_d   = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!m_busy) begin
          state_d = FINISH;
          ack_d   = gnt_q;
        end else if (timed_out) begin
          state_d = FINISH;
          ack_d   = gnt_q;
          err_d   = 1'b1;
        end
      end
      FINISH: begin
        state_d = IDLE;
        gnt_d   = '0;
`ifndef SPI_ARB_FIXED_PRI_EN
        if (int'(win_q) == NUM_REQ - 1) begin
          ptr_d = '0;
        end else begin
          ptr_d = win_q + PTR_W'(1);
        end
`endif
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase

    if (state_d != state_q) begin
      timer_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      ack_q     <= '0;
      err_q     <= 1'b0;
      m_start_q <= 1'b0;
      m_data_q  <= '0;
      timer_q   <= '0;
`ifndef SPI_ARB_FIXED_PRI_EN
      ptr_q     <= '0;
      win_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      m_start_q <= m_start_d;
      m_data_q  <= m_data_d;
      timer_q   <= timer_d;
`ifndef SPI_ARB_FIXED_PRI_EN
      ptr_q     <= ptr_d;
      win_q     <= win_d;
`endif
    end
  end

  assign gnt     = gnt_q;
  assign ack     = ack_q;
  assign err     = err_q;
  assign m_start = m_start_q;
  assign m_data  = m_data_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter (NUM_REQ=4, DATA_W=12, TIMEOUT=15).
module tb_spi_txn_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [47:0] req_data;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic        err;
  logic        m_start;
  logic [11:0] m_data;
  logic        m_busy;

  int checks = 0;
  int errors = 0;

  spi_txn_arbiter #(
    .NUM_REQ (4),
    .DATA_W  (12),
    .TIMEOUT (15)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .ack      (ack),
    .err      (err),
    .m_start  (m_start),
    .m_data   (m_data),
    .m_busy   (m_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete frame: grant, busy held for nbusy cycles, ack, then release.
  task automatic do_txn(input int idx, input logic [11:0] dat, input int nbusy);
    tick();
    chk("grant", 32'(gnt), 32'(1) << idx);
    chk("start", 32'(m_start), 32'd1);
    chk("data", 32'(m_data), 32'(dat));
    chk("no_ack_at_grant", 32'(ack), 32'd0);
    m_busy = 1'b1;
    repeat (nbusy) begin
      tick();
      chk("gnt_hold", 32'(gnt), 32'(1) << idx);
      chk("start_low", 32'(m_start), 32'd0);
      chk("no_ack", 32'(ack), 32'd0);
    end
    m_busy = 1'b0;
    tick();
    chk("ack", 32'(ack), 32'(1) << idx);
    chk("err_clear", 32'(err), 32'd0);
    chk("data_stable", 32'(m_data), 32'(dat));
    tick();
    chk("gnt_release", 32'(gnt), 32'd0);
    chk("ack_pulse", 32'(ack), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    req      = 4'b0000;
    req_data = {12'h444, 12'h333, 12'hA5C, 12'h111};
    m_busy   = 1'b0;
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_start", 32'(m_start), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_no_gnt", 32'(gnt), 32'd0);

    // Single requester 1.
    req = 4'b0010;
    do_txn(1, 12'hA5C, 8);
    req = 4'b0000;
    req_data[23:12] = 12'h222;

    // All four requesting from a fresh reset.
    reset = 1'b1;
    tick();
    reset = 1'b0;
`ifdef SPI_ARB_FIXED_PRI_EN
    req = 4'b1001;
    do_txn(0, 12'h111, 2);
    do_txn(0, 12'h111, 2);
    do_txn(0, 12'h111, 2);
`else
    req = 4'b1111;
    do_txn(0, 12'h111, 2);
    do_txn(1, 12'h222, 2);
    do_txn(2, 12'h333, 2);
    do_txn(3, 12'h444, 2);
    do_txn(0, 12'h111, 2);
`endif
    req = 4'b0000;

    // Busy never rises: timeout out of WAIT_BUSY, then requester 3 is served.
    req = 4'b1100;
    tick();
    chk("to_grant", 32'(gnt), 32'b0100);
    chk("to_start", 32'(m_start), 32'd1);
    repeat (15) begin
      tick();
      chk("to_no_ack", 32'(ack), 32'd0);
    end
    tick();
    chk("to_ack", 32'(ack), 32'b0100);
    chk("to_err", 32'(err), 32'd1);
    chk("to_gnt_finish", 32'(gnt), 32'b0100);
    req = 4'b1000;
    tick();
    chk("to_release", 32'(gnt), 32'd0);
    chk("to_err_pulse", 32'(err), 32'd0);
    do_txn(3, 12'h444, 2);
    req = 4'b0000;

    // Busy never falls: timeout out of WAIT_DONE.
    req = 4'b0001;
    tick();
    chk("tod_grant", 32'(gnt), 32'b0001);
    m_busy = 1'b1;
    tick();
    repeat (15) begin
      tick();
      chk("tod_no_ack", 32'(ack), 32'd0);
    end
    tick();
    chk("tod_ack", 32'(ack), 32'b0001);
    chk("tod_err", 32'(err), 32'd1);
    m_busy = 1'b0;
    req    = 4'b0000;
    tick();
    chk("tod_release", 32'(gnt), 32'd0);

    // Busy rises in the same cycle the timer hits its limit: no error.
    req = 4'b0001;
    tick();
    chk("race_grant", 32'(gnt), 32'b0001);
    repeat (15) begin
      tick();
      chk("race_no_ack", 32'(ack), 32'd0);
    end
    m_busy = 1'b1;
    tick();
    chk("race_still_busy_ack", 32'(ack), 32'd0);
    chk("race_still_busy_err", 32'(err), 32'd0);
    m_busy = 1'b0;
    tick();
    chk("race_ack", 32'(ack), 32'b0001);
    chk("race_err", 32'(err), 32'd0);
    req = 4'b0000;
    tick();

    // Request dropped and data changed while the frame is in flight.
    req = 4'b0010;
    tick();
    chk("drop_grant", 32'(gnt), 32'b0010);
    chk("drop_data", 32'(m_data), 32'h222);
    m_busy = 1'b1;
    tick();
    req = 4'b0000;
    req_data[23:12] = 12'hBAD;
    tick();
    chk("drop_gnt_hold", 32'(gnt), 32'b0010);
    chk("drop_data_hold", 32'(m_data), 32'h222);
    tick();
    m_busy = 1'b0;
    tick();
    chk("drop_ack", 32'(ack), 32'b0010);
    chk("drop_err", 32'(err), 32'd0);
    chk("drop_data_end", 32'(m_data), 32'h222);
    tick();
    chk("drop_release", 32'(gnt), 32'd0);
    req_data[23:12] = 12'h222;

    // Reset in WAIT_DONE aborts silently and restarts the pointer at 0.
    req = 4'b0100;
    tick();
    chk("rstmid_grant", 32'(gnt), 32'b0100);
    m_busy = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    chk("rstmid_gnt", 32'(gnt), 32'd0);
    chk("rstmid_ack", 32'(ack), 32'd0);
    chk("rstmid_err", 32'(err), 32'd0);
    chk("rstmid_start", 32'(m_start), 32'd0);
    chk("rstmid_data", 32'(m_data), 32'd0);
    reset  = 1'b0;
    m_busy = 1'b0;
    req    = 4'b0101;
    do_txn(0, 12'h111, 2);
    req = 4'b0000;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
